// File: rtl/row_buffer_reader_padded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : row_buffer_pkg                                               |
// | Description : Shared helpers and types for the row-buffer reader/writer.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package row_buffer_pkg;

    localparam int PIXEL_W = 8;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int ceil(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

    function automatic int log2(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_buffer_reader_padded_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : row_buffer_reader_padded_if                                  |
// | Description : Control, RAM read port and PE stream of the row reader.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface row_buffer_reader_padded_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IW         = 7,
    parameter int BANK_COUNT = 4,
    parameter int OUT_IW     = 7,
    parameter int ADDR_WIDTH = 32
);
    logic                                buffer_reader_en;
    logic                                buffer_reader_done;
    logic [BANK_COUNT*ADDR_WIDTH-1:0]    buffer_reader_ram_rd_addr;
    logic [BANK_COUNT*IW*DATA_WIDTH-1:0] buffer_reader_ram_rd_data;
    logic [OUT_IW*DATA_WIDTH-1:0]        row2pe_data;
    logic                                row2pe_valid;
    logic                                row2pe_ready;
    logic                                row2pe_last;
    logic                                row2pe_last_ch;

    modport master (
        input  buffer_reader_en,
        input  buffer_reader_ram_rd_data,
        input  row2pe_ready,
        output buffer_reader_done,
        output buffer_reader_ram_rd_addr,
        output row2pe_data,
        output row2pe_valid,
        output row2pe_last,
        output row2pe_last_ch
    );

    modport slave (
        output buffer_reader_en,
        output buffer_reader_ram_rd_data,
        output row2pe_ready,
        input  buffer_reader_done,
        input  buffer_reader_ram_rd_addr,
        input  row2pe_data,
        input  row2pe_valid,
        input  row2pe_last,
        input  row2pe_last_ch
    );

endinterface
`default_nettype wire

// File: rtl/row_buffer_reader_padded_pad_slicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : row_pad_slicer                                               |
// | Description : Zero-pads a latched row and selects one OUT_IW-wide beat.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module row_pad_slicer
    import row_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HIN        = 28,
    parameter int OUT_IW     = 7,
    parameter int PAD        = 1,
    parameter int BEAT_W     = 4
) (
    input  wire logic [HIN*DATA_WIDTH-1:0]    i_row,
    input  wire logic [BEAT_W-1:0]            i_beat,
    output logic      [OUT_IW*DATA_WIDTH-1:0] o_data
);

    localparam int c_bpc      = ceil(HIN + 2*PAD, OUT_IW);
    localparam int c_beat_bits = OUT_IW * DATA_WIDTH;

    // Padded row including the zero tail that rounds it up to whole beats.
    logic [c_bpc*c_beat_bits-1:0] w_padded;

    generate
        for (genvar p = 0; p < c_bpc*OUT_IW; p++) begin : g_pos
            if (p >= PAD && p < PAD + HIN) begin : g_pix
                assign w_padded[p*DATA_WIDTH +: DATA_WIDTH] = i_row[(p-PAD)*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_zero
                assign w_padded[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    endgenerate

    always_comb begin
        o_data = '0;
        for (int b = 0; b < c_bpc; b++) begin
            if (int'(i_beat) == b) begin
                o_data = w_padded[b*c_beat_bits +: c_beat_bits];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_buffer_reader_padded.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : row_buffer_reader_padded                                     |
// | Description : Drains one row per channel from the banks, streams padded    |
// |               OUT_IW-wide beats to the next PE array.                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module row_buffer_reader_padded
    import row_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HIN        = 28,
    parameter int IW         = 7,
    parameter int BANK_COUNT = 4,
    parameter int OUT_IW     = 7,
    parameter int PAD        = 1,
    parameter int C          = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    row_buffer_reader_padded_if.master bus
);

    localparam int c_pw     = HIN + 2*PAD;
    localparam int c_bpc    = ceil(c_pw, OUT_IW);
    localparam int c_ch_w   = log2(C) + 1;
    localparam int c_beat_w = log2(c_bpc) + 1;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_ch_w-1:0]            r_ch;
    logic [c_beat_w-1:0]          r_beat;
    logic [HIN*DATA_WIDTH-1:0]    r_row;
    logic [HIN*DATA_WIDTH-1:0]    w_row_in;
    logic                         r_done;
    logic                         w_stream;
    logic                         w_fire;
    logic                         w_last_beat;
    logic                         w_last_ch;
    logic [OUT_IW*DATA_WIDTH-1:0] w_beat_data;

    // Bank b word j lands at row pixel b*IW+j; words past HIN are dropped.
    generate
        for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
            for (genvar j = 0; j < IW; j++) begin : g_word
                if (b*IW + j < HIN) begin : g_keep
                    assign w_row_in[(b*IW+j)*DATA_WIDTH +: DATA_WIDTH] =
                        bus.buffer_reader_ram_rd_data[(b*IW+j)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    endgenerate

    assign w_stream    = (r_state == STREAM);
    assign w_fire      = w_stream && bus.row2pe_ready;
    assign w_last_beat = (r_beat == c_beat_w'(c_bpc - 1));
    assign w_last_ch   = (r_ch == c_ch_w'(C - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.buffer_reader_en) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = STREAM;
            STREAM:  if (w_fire && w_last_beat) w_state_nxt = w_last_ch ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_beat  <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.buffer_reader_en) begin
                        r_done <= 1'b0;
                        r_ch   <= '0;
                        r_beat <= '0;
                    end
                end
                WAIT: r_row <= w_row_in;
                STREAM: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (w_last_ch) begin
                                r_done <= 1'b1;
                            end else begin
                                r_ch <= r_ch + 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                DONE: r_ch <= '0;
                default: ;
            endcase
        end
    end

    row_pad_slicer #(
        .DATA_WIDTH (DATA_WIDTH),
        .HIN        (HIN),
        .OUT_IW     (OUT_IW),
        .PAD        (PAD),
        .BEAT_W     (c_beat_w)
    ) u_slicer (
        .i_row  (r_row),
        .i_beat (r_beat),
        .o_data (w_beat_data)
    );

    // The address is the channel at all times; it only matters while fetching.
    assign bus.buffer_reader_ram_rd_addr = {BANK_COUNT{ADDR_WIDTH'(r_ch)}};
    assign bus.buffer_reader_done        = r_done;
    assign bus.row2pe_data               = w_beat_data;
    assign bus.row2pe_valid              = w_stream;
    assign bus.row2pe_last               = w_stream && w_last_beat;
    assign bus.row2pe_last_ch            = w_stream && w_last_beat && w_last_ch;

endmodule
`default_nettype wire

// File: tb/tb_row_buffer_reader_padded.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_row_buffer_reader_padded                                  |
// | Description : Self-checking bench for the padded row-buffer reader.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_row_buffer_reader_padded;
    import row_buffer_pkg::*;

    localparam int DW   = 8;
    localparam int HIN  = 28;
    localparam int IW   = 7;
    localparam int NB   = 4;
    localparam int OIW  = 7;
    localparam int PAD  = 1;
    localparam int C    = 256;
    localparam int AW   = 32;
    localparam int BPC  = 5;
    localparam int NBEATS = C * BPC;

    logic clk;
    logic rst;

    row_buffer_reader_padded_if #(
        .DATA_WIDTH(DW), .IW(IW), .BANK_COUNT(NB), .OUT_IW(OIW), .ADDR_WIDTH(AW)
    ) bus ();

    row_buffer_reader_padded #(
        .DATA_WIDTH(DW), .HIN(HIN), .IW(IW), .BANK_COUNT(NB), .OUT_IW(OIW),
        .PAD(PAD), .C(C), .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM banks: word j of bank b at address c holds (c + b*IW + j) & 0xFF.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < IW; j++) begin
                bus.buffer_reader_ram_rd_data[(b*IW+j)*DW +: DW] <=
                    8'((int'(bus.buffer_reader_ram_rd_addr[AW-1:0]) + b*IW + j) & 255);
            end
        end
    end

    // Expected beat straight from the padding rule on the RAM contents.
    function automatic logic [OIW*DW-1:0] exp_data(input int c, input int b);
        logic [OIW*DW-1:0] r;
        pixel_t px;
        r = '0;
        for (int j = 0; j < OIW; j++) begin
            int p;
            p = b*OIW + j;
            if (p >= PAD && p < PAD + HIN) begin
                px = pixel_t'((c + p - PAD) & 255);
                r[j*DW +: DW] = px;
            end
        end
        return r;
    endfunction

    logic [OIW*DW-1:0] lit_c0b0 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic [OIW*DW-1:0] lit_c0b4 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd27};
    logic [OIW*DW-1:0] lit_c5b0 = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd0};

    // Ready generator: constant 1 or the repeating 1,0,0,1 pattern.
    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    int         bp_cyc  = 0;
    initial begin
        bus.row2pe_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bp_cyc = bp_cyc + 1;
            bus.row2pe_ready = bp_mode ? bp_pat[bp_cyc % 4] : 1'b1;
        end
    end

    // Model state, owned by the monitor; run_id from the stimulus restarts it.
    int                run_id = 0;
    int                seen_run = 0;
    int                exp_ch = 0;
    int                exp_beat = 0;
    int                run_beats = 0;
    int                run_last = 0;
    int                run_lastch = 0;
    bit                pend_done = 0;
    bit                pend_fetch = 0;
    bit                stalled = 0;
    logic [OIW*DW-1:0] stall_data;
    logic              stall_last;
    logic              stall_lastch;

    always @(negedge clk) begin
        if (seen_run != run_id) begin
            seen_run   = run_id;
            exp_ch     = 0;
            exp_beat   = 0;
            run_beats  = 0;
            run_last   = 0;
            run_lastch = 0;
        end
        if (rst) begin
            pend_done  = 0;
            pend_fetch = 0;
            stalled    = 0;
        end else begin
            if (pend_done) begin
                chk("done_after_last", longint'(bus.buffer_reader_done), 1);
                chk("valid_in_done", longint'(bus.row2pe_valid), 0);
                pend_done = 0;
            end
            if (pend_fetch) begin
                chk("rd_addr_fetch", longint'(bus.buffer_reader_ram_rd_addr), longint'({NB{AW'(exp_ch)}}));
                chk("valid_in_fetch", longint'(bus.row2pe_valid), 0);
                pend_fetch = 0;
            end
            if (stalled) begin
                chk("stall_valid", longint'(bus.row2pe_valid), 1);
                chk("stall_data", longint'(bus.row2pe_data), longint'(stall_data));
                chk("stall_last", longint'({bus.row2pe_last, bus.row2pe_last_ch}),
                    longint'({stall_last, stall_lastch}));
            end
            stalled = 0;
            if (bus.row2pe_valid) begin
                chk("beat_data", longint'(bus.row2pe_data), longint'(exp_data(exp_ch, exp_beat)));
                chk("beat_last", longint'(bus.row2pe_last), longint'(exp_beat == BPC-1));
                chk("beat_last_ch", longint'(bus.row2pe_last_ch),
                    longint'(exp_beat == BPC-1 && exp_ch == C-1));
                chk("done_while_stream", longint'(bus.buffer_reader_done), 0);
                if (exp_ch == 0 && exp_beat == 0)
                    chk("lit_ch0_beat0", longint'(bus.row2pe_data), longint'(lit_c0b0));
                if (exp_ch == 0 && exp_beat == 4)
                    chk("lit_ch0_beat4", longint'(bus.row2pe_data), longint'(lit_c0b4));
                if (exp_ch == 5 && exp_beat == 0)
                    chk("lit_ch5_beat0", longint'(bus.row2pe_data), longint'(lit_c5b0));
                if (bus.row2pe_ready) begin
                    run_beats++;
                    if (bus.row2pe_last)    run_last++;
                    if (bus.row2pe_last_ch) run_lastch++;
                    if (exp_beat == BPC-1) begin
                        exp_beat = 0;
                        if (exp_ch == C-1) begin
                            pend_done = 1;
                        end else begin
                            exp_ch++;
                            pend_fetch = 1;
                        end
                    end else begin
                        exp_beat++;
                    end
                end else begin
                    stalled      = 1;
                    stall_data   = bus.row2pe_data;
                    stall_last   = bus.row2pe_last;
                    stall_lastch = bus.row2pe_last_ch;
                end
            end
        end
    end

    // Starts a run, checks the en->FETCH->WAIT->STREAM latency, optionally
    // pulses en in each busy state, and waits for done.
    task automatic do_run(input bit inject);
        bit ok;
        run_id = run_id + 1;
        @(posedge clk); #1; bus.buffer_reader_en = 1'b1;
        @(posedge clk); #1; bus.buffer_reader_en = inject;
        @(negedge clk);
        chk("lat_fetch_addr", longint'(bus.buffer_reader_ram_rd_addr), 0);
        chk("lat_fetch_valid", longint'(bus.row2pe_valid), 0);
        chk("done_cleared", longint'(bus.buffer_reader_done), 0);
        @(posedge clk); #1; bus.buffer_reader_en = inject;
        @(negedge clk);
        chk("lat_wait_valid", longint'(bus.row2pe_valid), 0);
        @(posedge clk); #1; bus.buffer_reader_en = inject;
        @(negedge clk);
        chk("lat_first_valid", longint'(bus.row2pe_valid), 1);
        @(posedge clk); #1; bus.buffer_reader_en = 1'b0;
        ok = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (bus.buffer_reader_done) begin
                ok = 1;
                break;
            end
        end
        chk("run_timeout", longint'(ok), 1);
        @(negedge clk);
        chk("run_beats", longint'(run_beats), NBEATS);
        chk("run_last_count", longint'(run_last), C);
        chk("run_last_ch_count", longint'(run_lastch), 1);
        repeat (3) @(negedge clk);
        chk("done_held_idle", longint'(bus.buffer_reader_done), 1);
        chk("idle_valid", longint'(bus.row2pe_valid), 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        bus.buffer_reader_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", longint'(bus.row2pe_valid), 0);
        chk("rst_done", longint'(bus.buffer_reader_done), 0);
        chk("rst_last", longint'({bus.row2pe_last, bus.row2pe_last_ch}), 0);
        chk("rst_rd_addr", longint'(bus.buffer_reader_ram_rd_addr), 0);
        chk("rst_data", longint'(bus.row2pe_data), 0);
        @(posedge clk); #1; rst = 1'b0;

        bp_mode = 1'b0;
        do_run(1'b0);
        bp_mode = 1'b1;
        do_run(1'b0);
        bp_mode = 1'b0;
        do_run(1'b1);

        // Abandon a run partway through channel 10.
        run_id = run_id + 1;
        @(posedge clk); #1; bus.buffer_reader_en = 1'b1;
        @(posedge clk); #1; bus.buffer_reader_en = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_ch == 10 && exp_beat == 2) begin
                ok = 1;
                break;
            end
        end
        chk("reach_ch10_timeout", longint'(ok), 1);
        #2; rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", longint'(bus.row2pe_valid), 0);
        chk("midrst_done", longint'(bus.buffer_reader_done), 0);
        chk("midrst_rd_addr", longint'(bus.buffer_reader_ram_rd_addr), 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", longint'(bus.buffer_reader_done), 0);
        do_run(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
